// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory boot loader.
// Default geometry matches the instruction memory it fills.
package imem_loader_pkg;

  localparam int WIDTH_DEF = 32;
  localparam int DEPTH_DEF = 32;
  localparam int AW_DEF    = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    LAST = 2'd2
  } ld_state_e;

  function automatic int bpw(input int width);
    return width / 8;
  endfunction

  function automatic int cnt_w(input int width);
    return (width / 8 > 1) ? $clog2(width / 8) : 1;
  endfunction

endpackage

// File: rtl/imem_loader_word_assembler.sv
// Packs bytes little-endian into one instruction word.
// Owns the lane counter; flags the byte that completes a word.
module word_assembler
  import imem_loader_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic [7:0]       data_i,
  output logic [WIDTH-1:0] word_o,
  output logic             full_o
);

  localparam int BPW = bpw(WIDTH);
  localparam int BCW = cnt_w(WIDTH);

  logic [BCW-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0] word_q, word_d;
  logic             last_lane;

  assign last_lane = (cnt_q == BCW'(BPW - 1));

  always_comb begin
    word_d = word_q;
    cnt_d  = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      word_d[8*cnt_q +: 8] = data_i;
      cnt_d = last_lane ? '0 : cnt_q + 1'b1;
    end
  end

  // The completing byte is not yet registered, so expose the merged word.
  assign word_o = word_d;
  assign full_o = en_i & last_lane & ~clr_i;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q  <= '0;
      word_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      word_q <= word_d;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Boot-time loader: byte stream in, packed words out to the
// instruction memory write port; holds the core while busy.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int DEPTH = DEPTH_DEF,
  parameter int AW    = AW_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [AW:0]      load_len,
  input  logic             byte_valid,
  input  logic [7:0]       byte_data,
  output logic             byte_ready,
  output logic             wr_en,
  output logic [AW-1:0]    wr_addr,
  output logic [WIDTH-1:0] wr_data,
  output logic             busy,
  output logic             done,
  output logic             err
);

  ld_state_e        state_q, state_d;
  logic [AW:0]      word_cnt_q, word_cnt_d;
  logic [AW:0]      len_q, len_d;
  logic             err_q, err_d;
  logic             done_q, done_d;
  logic             wr_en_q, wr_en_d;
  logic [AW-1:0]    wr_addr_q, wr_addr_d;
  logic [WIDTH-1:0] wr_data_q, wr_data_d;

  logic             byte_acc;
  logic             asm_clr;
  logic             word_full;
  logic [WIDTH-1:0] asm_word;
  logic             last_word;

  assign byte_ready = (state_q == LOAD);
  assign busy       = (state_q != IDLE);
  assign byte_acc   = byte_valid & byte_ready;
  assign last_word  = (word_cnt_q == len_q - 1'b1);

  word_assembler #(
    .WIDTH (WIDTH)
  ) u_asm (
    .clk    (clk),
    .reset  (reset),
    .clr_i  (asm_clr),
    .en_i   (byte_acc),
    .data_i (byte_data),
    .word_o (asm_word),
    .full_o (word_full)
  );

  always_comb begin
    state_d    = state_q;
    word_cnt_d = word_cnt_q;
    len_d      = len_q;
    err_d      = err_q;
    done_d     = 1'b0;
    wr_en_d    = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    asm_clr    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (load_len == '0) begin
            done_d = 1'b1;
            err_d  = 1'b0;
          end else if (load_len > (AW+1)'(DEPTH)) begin
            err_d = 1'b1;
          end else begin
            state_d    = LOAD;
            word_cnt_d = '0;
            len_d      = load_len;
            err_d      = 1'b0;
            asm_clr    = 1'b1;
          end
        end
      end
      LOAD: begin
        if (word_full) begin
          wr_en_d    = 1'b1;
          wr_addr_d  = word_cnt_q[AW-1:0];
          wr_data_d  = asm_word;
          word_cnt_d = word_cnt_q + 1'b1;
          // Final word: its write and done land together in LAST.
          if (last_word) begin
            state_d = LAST;
            done_d  = 1'b1;
          end
        end
      end
      LAST: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      word_cnt_q <= '0;
      len_q      <= '0;
      err_q      <= 1'b0;
      done_q     <= 1'b0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      word_cnt_q <= word_cnt_d;
      len_q      <= len_d;
      err_q      <= err_d;
      done_q     <= done_d;
      wr_en_q    <= wr_en_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
    end
  end

  assign wr_en   = wr_en_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;
  assign done    = done_q;
  assign err     = err_q;

endmodule
